// File: rtl/array_op_scheduler.sv
// Command scheduler feeding one array operation at a time to the WL/BL/SL row controllers.
// Optional: define ARRAY_SCHED_VERIFY_EN for program-and-verify writes with WL voltage stepping.
module array_op_scheduler #(
  parameter int         CMD_DEPTH = 4,
  parameter logic [7:0] TIMEOUT   = 8'd255,
  parameter logic [2:0] MAX_RETRY = 3'd3,
  parameter logic [7:0] VOL_STEP  = 8'd4
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_mode,
  input  logic [4:0] cmd_wl_addr,
  input  logic [4:0] cmd_bl_addr,
  input  logic [7:0] cmd_wl_vol,
  input  logic [7:0] cmd_target,
  output logic       work_en,
  output logic       work_mode,
  output logic [4:0] wl_addr_in,
  output logic [4:0] bl_addr_in,
  output logic [7:0] wl_digital_vol_in,
  input  logic       op_down_com,
  input  logic       read_down,
  input  logic [7:0] adc_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [1:0] rsp_status,
  output logic [7:0] rsp_data,
  output logic [2:0] rsp_retries,
  output logic       busy
);
  localparam int AW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(CMD_DEPTH);
  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_VFAIL = 2'b01;
  localparam logic [1:0] ST_TOUT = 2'b10;

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_OP, CHECK, RESP
  } state_e;

  state_e        state_q;
  logic [26:0]   mem_q [CMD_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          push, pop, done;
  logic [26:0]   head;

  logic       work_en_q, wmode_q, mode_q;
  logic [4:0] wl_q, bl_q;
  logic [7:0] vol_q, tgt_q, timer_q, adc_q;
  logic [2:0] retries_q;
  logic       rsp_valid_q;
  logic [1:0] rsp_status_q;
  logic [7:0] rsp_data_q;
  logic [2:0] rsp_retries_q;

  assign cmd_ready = (cnt_q != FULL);
  assign push = cmd_valid && cmd_ready;
  assign pop = (state_q == IDLE) && (cnt_q != '0);
  assign head = mem_q[rd_ptr_q];
  assign busy = (state_q != IDLE) || (cnt_q != '0);
  assign done = wmode_q ? op_down_com : read_down;

  assign work_en = work_en_q;
  assign work_mode = wmode_q;
  assign wl_addr_in = wl_q;
  assign bl_addr_in = bl_q;
  assign wl_digital_vol_in = vol_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_status = rsp_status_q;
  assign rsp_data = rsp_data_q;
  assign rsp_retries = rsp_retries_q;

`ifdef ARRAY_SCHED_VERIFY_EN
  logic [8:0] vol_sum;
  logic [7:0] vol_step_d;
  logic       pass;
  assign vol_sum = {1'b0, vol_q} + {1'b0, VOL_STEP};
  assign vol_step_d = vol_sum[8] ? 8'hFF : vol_sum[7:0];
  assign pass = (adc_q >= tgt_q);
`else
  logic unused_cfg;
  assign unused_cfg = ^{tgt_q, MAX_RETRY, VOL_STEP};
`endif

  always_ff @(posedge sys_clk) begin
    if (push)
      mem_q[wr_ptr_q] <= {cmd_mode, cmd_wl_addr, cmd_bl_addr, cmd_wl_vol, cmd_target};
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10: cnt_q <= cnt_q + CW'(1);
        2'b01: cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      work_en_q <= 1'b0;
      wmode_q <= 1'b0;
      mode_q <= 1'b0;
      wl_q <= '0;
      bl_q <= '0;
      vol_q <= '0;
      tgt_q <= '0;
      timer_q <= '0;
      adc_q <= '0;
      retries_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_status_q <= '0;
      rsp_data_q <= '0;
      rsp_retries_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            mode_q <= head[26];
            wmode_q <= head[26];
            wl_q <= head[25:21];
            bl_q <= head[20:16];
            vol_q <= head[15:8];
            tgt_q <= head[7:0];
            retries_q <= '0;
            work_en_q <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          work_en_q <= 1'b0;
          timer_q <= TIMEOUT;
          state_q <= WAIT_OP;
        end
        WAIT_OP: begin
          // completion beats a coinciding timer expiry
          if (done) begin
            if (!wmode_q) adc_q <= adc_data;
            state_q <= CHECK;
          end else if (timer_q <= 8'd1) begin
            rsp_valid_q <= 1'b1;
            rsp_status_q <= ST_TOUT;
            rsp_data_q <= '0;
            rsp_retries_q <= retries_q;
            state_q <= RESP;
          end else begin
            timer_q <= timer_q - 8'd1;
          end
        end
        CHECK: begin
`ifdef ARRAY_SCHED_VERIFY_EN
          if (mode_q && wmode_q) begin
            wmode_q <= 1'b0;
            work_en_q <= 1'b1;
            state_q <= ISSUE;
          end else if (mode_q && !pass && retries_q < MAX_RETRY) begin
            retries_q <= retries_q + 3'd1;
            vol_q <= vol_step_d;
            wmode_q <= 1'b1;
            work_en_q <= 1'b1;
            state_q <= ISSUE;
          end else begin
            rsp_valid_q <= 1'b1;
            rsp_status_q <= (mode_q && !pass) ? ST_VFAIL : ST_OK;
            rsp_data_q <= adc_q;
            rsp_retries_q <= retries_q;
            state_q <= RESP;
          end
`else
          rsp_valid_q <= 1'b1;
          rsp_status_q <= ST_OK;
          rsp_data_q <= mode_q ? 8'd0 : adc_q;
          rsp_retries_q <= retries_q;
          state_q <= RESP;
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_array_op_scheduler.sv
// Scoreboard bench for array_op_scheduler with a behavioural row-controller model.
module tb_array_op_scheduler;
  localparam logic [7:0] TMO = 8'd255;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_mode = 1'b0;
  logic [4:0] cmd_wl_addr = '0;
  logic [4:0] cmd_bl_addr = '0;
  logic [7:0] cmd_wl_vol = '0;
  logic [7:0] cmd_target = '0;
  logic       work_en, work_mode;
  logic [4:0] wl_addr_in, bl_addr_in;
  logic [7:0] wl_digital_vol_in;
  logic       op_down_com = 1'b0;
  logic       read_down = 1'b0;
  logic [7:0] adc_data = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [1:0] rsp_status;
  logic [7:0] rsp_data;
  logic [2:0] rsp_retries;
  logic       busy;

  array_op_scheduler #(
    .CMD_DEPTH(4), .TIMEOUT(TMO), .MAX_RETRY(3'd3), .VOL_STEP(8'd4)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_wl_addr(cmd_wl_addr),
    .cmd_bl_addr(cmd_bl_addr), .cmd_wl_vol(cmd_wl_vol),
    .cmd_target(cmd_target),
    .work_en(work_en), .work_mode(work_mode),
    .wl_addr_in(wl_addr_in), .bl_addr_in(bl_addr_in),
    .wl_digital_vol_in(wl_digital_vol_in),
    .op_down_com(op_down_com), .read_down(read_down),
    .adc_data(adc_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status), .rsp_data(rsp_data),
    .rsp_retries(rsp_retries), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [1:0] st;
    logic [7:0] data;
    logic [2:0] rt;
    int         lat;
  } rsp_t;
  typedef struct {
    logic       mode;
    logic [4:0] wl;
    logic [4:0] bl;
    logic [7:0] vol;
  } iss_t;

  rsp_t sb[$];
  iss_t iq[$];
  logic [7:0] adcq[$];
  rsp_t r_cur;
  iss_t i_cur;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   we_cyc = 0;
  int   nrsp = 0;
  int   delay = 20;
  bit   hang = 1'b0;
  logic [7:0] adc_dflt = 8'h00;
  int   cnt = 0;
  logic pmode = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_rsp(input logic [1:0] st, input logic [7:0] d, input logic [2:0] rt,
                         input int lat);
    rsp_t e;
    e.st = st; e.data = d; e.rt = rt; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic exp_iss(input logic m, input logic [4:0] wl, input logic [4:0] bl,
                         input logic [7:0] vol);
    iss_t e;
    e.mode = m; e.wl = wl; e.bl = bl; e.vol = vol;
    iq.push_back(e);
  endtask

  task automatic push(input logic m, input logic [4:0] wl, input logic [4:0] bl,
                      input logic [7:0] vol, input logic [7:0] tgt);
    int b;
    b = 0;
    @(negedge sys_clk);
    cmd_mode = m; cmd_wl_addr = wl; cmd_bl_addr = bl;
    cmd_wl_vol = vol; cmd_target = tgt; cmd_valid = 1'b1;
    while (!cmd_ready && b < 3000) begin
      @(negedge sys_clk);
      b++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL push_wait: cmd_ready stuck low after %0d cycles", b);
    end
    @(posedge sys_clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while ((sb.size() != 0 || busy) && b < 3000) begin
      @(negedge sys_clk);
      b++;
    end
    checks++;
    if (b >= 3000) begin
      errors++;
      $display("FAIL wait_idle: busy=%0d pending=%0d", busy, sb.size());
    end
  endtask

  always @(posedge sys_clk) cyc = cyc + 1;

  // row-controller model: answers each work_en after `delay` cycles unless hung
  always @(negedge sys_clk) begin
    op_down_com = 1'b0;
    read_down = 1'b0;
    if (!sys_rst_n) begin
      cnt = 0;
    end else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          if (pmode) op_down_com = 1'b1;
          else begin
            read_down = 1'b1;
            adc_data = (adcq.size() != 0) ? adcq.pop_front() : adc_dflt;
          end
        end
      end
      if (work_en) begin
        we_cyc = cyc;
        pmode = work_mode;
        cnt = hang ? 0 : delay;
        if (iq.size() == 0) begin
          checks++; errors++;
          $display("FAIL issue_unexpected: mode=%0d wl=%0d bl=%0d",
                   work_mode, wl_addr_in, bl_addr_in);
        end else begin
          i_cur = iq.pop_front();
          chk("issue", {work_mode, wl_addr_in, bl_addr_in, wl_digital_vol_in},
              {i_cur.mode, i_cur.wl, i_cur.bl, i_cur.vol});
        end
      end
    end
  end

  always @(negedge sys_clk) begin
    if (sys_rst_n && rsp_valid) begin
      nrsp++;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp_unexpected: status=%0d data=%0h", rsp_status, rsp_data);
      end else begin
        r_cur = sb.pop_front();
        chk("rsp", {rsp_status, rsp_data, rsp_retries}, {r_cur.st, r_cur.data, r_cur.rt});
        if (r_cur.lat > 0) chk("rsp_lat", 64'(cyc - we_cyc), 64'(r_cur.lat));
      end
    end
  end

  int n0;

  initial begin
    #2 sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_outs", {work_en, work_mode, wl_addr_in, bl_addr_in, wl_digital_vol_in,
                     rsp_valid, rsp_status, rsp_data, rsp_retries, busy}, 0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // single read
    delay = 20;
    adcq.push_back(8'h40);
    exp_iss(1'b0, 5'd5, 5'd3, 8'h33);
    exp_rsp(2'b00, 8'h40, 3'd0, 22);
    push(1'b0, 5'd5, 5'd3, 8'h33, 8'h00);
    wait_idle();

    // back-to-back burst against a slow controller
    delay = 30;
    n0 = nrsp;
    for (int i = 0; i < 6; i++) begin
      adcq.push_back(8'hA0 + 8'(i));
      exp_iss(1'b0, 5'(i + 1), 5'(i + 10), 8'h20 + 8'(i));
      exp_rsp(2'b00, 8'hA0 + 8'(i), 3'd0, 32);
    end
    for (int i = 0; i < 5; i++)
      push(1'b0, 5'(i + 1), 5'(i + 10), 8'h20 + 8'(i), 8'h00);
    @(negedge sys_clk);
    chk("burst_full", cmd_ready, 0);
    chk("burst_busy", busy, 1);
    push(1'b0, 5'd6, 5'd15, 8'h25, 8'h00);
    chk("sixth_after_pop", 64'(nrsp - n0), 1);
    wait_idle();
    chk("burst_count", 64'(nrsp - n0), 6);

    // write with a dead controller, then a normal read
    hang = 1'b1;
    exp_iss(1'b1, 5'd7, 5'd9, 8'h55);
    exp_rsp(2'b10, 8'h00, 3'd0, int'(TMO) + 1);
    push(1'b1, 5'd7, 5'd9, 8'h55, 8'h80);
    wait_idle();
    hang = 1'b0;
    delay = 5;
    adcq.push_back(8'h77);
    exp_iss(1'b0, 5'd31, 5'd0, 8'hFF);
    exp_rsp(2'b00, 8'h77, 3'd0, 7);
    push(1'b0, 5'd31, 5'd0, 8'hFF, 8'h00);
    wait_idle();

`ifdef ARRAY_SCHED_VERIFY_EN
    delay = 10;
    adcq.push_back(8'h20); adcq.push_back(8'h50); adcq.push_back(8'h90);
    exp_iss(1'b1, 5'd2, 5'd4, 8'h10); exp_iss(1'b0, 5'd2, 5'd4, 8'h10);
    exp_iss(1'b1, 5'd2, 5'd4, 8'h14); exp_iss(1'b0, 5'd2, 5'd4, 8'h14);
    exp_iss(1'b1, 5'd2, 5'd4, 8'h18); exp_iss(1'b0, 5'd2, 5'd4, 8'h18);
    exp_rsp(2'b00, 8'h90, 3'd2, 0);
    push(1'b1, 5'd2, 5'd4, 8'h10, 8'h80);
    wait_idle();
    adc_dflt = 8'h00;
    exp_iss(1'b1, 5'd8, 5'd1, 8'hFC); exp_iss(1'b0, 5'd8, 5'd1, 8'hFC);
    for (int i = 0; i < 3; i++) begin
      exp_iss(1'b1, 5'd8, 5'd1, 8'hFF); exp_iss(1'b0, 5'd8, 5'd1, 8'hFF);
    end
    exp_rsp(2'b01, 8'h00, 3'd3, 0);
    push(1'b1, 5'd8, 5'd1, 8'hFC, 8'h80);
    wait_idle();
`else
    delay = 4;
    exp_iss(1'b1, 5'd2, 5'd4, 8'h10);
    exp_rsp(2'b00, 8'h00, 3'd0, 6);
    push(1'b1, 5'd2, 5'd4, 8'h10, 8'h80);
    wait_idle();
`endif

    // reset while one op waits and two are queued
    hang = 1'b1;
    n0 = nrsp;
    for (int i = 0; i < 3; i++) begin
      exp_iss(1'b0, 5'(i + 20), 5'd2, 8'h01);
      exp_rsp(2'b00, 8'h00, 3'd0, 0);
      push(1'b0, 5'(i + 20), 5'd2, 8'h01, 8'h00);
    end
    repeat (5) @(negedge sys_clk);
    chk("pre_rst_busy", busy, 1);
    sys_rst_n = 1'b0;
    sb.delete();
    iq.delete();
    #1;
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_outs", {work_en, work_mode, wl_addr_in, bl_addr_in, wl_digital_vol_in,
                         rsp_valid, rsp_status, rsp_data, rsp_retries, busy}, 0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    hang = 1'b0;
    repeat (40) @(negedge sys_clk);
    chk("post_rst_idle", {busy, cmd_ready}, 2'b01);
    chk("post_rst_no_rsp", 64'(nrsp - n0), 0);
    chk("iq_drained", 64'(iq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
